// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: state encodings and the default
// tolerance / lock / timeout constants also used by the freq_gen benches.
`timescale 1ns/1ps
package period_meter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    CHECK   = 3'd2,
    LOCKED  = 3'd3,
    LOST    = 3'd4
  } state_e;

  localparam int DEFAULT_TOLERANCE     = 1;
  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_MAX_TICKS     = 65535;

endpackage

// File: rtl/period_meter_if.sv
// Reference-clock input, power-down and locked-period outputs of the meter.
`timescale 1ns/1ps
interface period_meter_if #(parameter int WIDTH = 32);

  logic             pwrdwn;
  logic             clk_in;
  logic [WIDTH-1:0] period_ticks;
  logic [31:0]      ref_period;
  logic             period_stable;
  logic             lost;

  modport master (output pwrdwn, clk_in,
                  input  period_ticks, ref_period, period_stable, lost);
  modport slave  (input  pwrdwn, clk_in,
                  output period_ticks, ref_period, period_stable, lost);

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a delay flop
// that turns each rising edge into a one-cycle pulse.
`timescale 1ns/1ps
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: non-blocking assignments so every stage takes its predecessor's old
  // value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// Measures the clk_in period in clk ticks and locks once STABLE_CYCLES
// consecutive periods agree within TOLERANCE; declares loss after MAX_TICKS.
`timescale 1ns/1ps
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SAMPLE_PERIOD = 1,
  parameter int TOLERANCE     = DEFAULT_TOLERANCE,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int MAX_TICKS     = DEFAULT_MAX_TICKS
) (
  input logic           clk,
  input logic           rst_n,
  period_meter_if.slave bus
);

  localparam int MW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_TICKS);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(MAX_TICKS - 1);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_W     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   TWO_W     = (WIDTH+1)'(2);
  localparam logic [WIDTH:0]   TOL_W     = (WIDTH+1)'(TOLERANCE);
  localparam logic [31:0]      SP_W      = 32'(SAMPLE_PERIOD);
  localparam logic [MW-1:0]    STABLE_M  = MW'(STABLE_CYCLES);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] ticks_q;
  logic [31:0]      ref_q;
  logic             load;
  logic             rise;
  logic             timeout;
  logic [WIDTH:0]   m;
  logic [31:0]      ref_d;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.clk_in),
    .rise (rise)
  );

  // Extra top bit keeps both the +1 and the difference below free of wrap.
  assign m       = {1'b0, cnt_q} + ONE_W;
  assign timeout = (cnt_q == TIMEOUT_W);
  assign ref_d   = 32'({{32{1'b0}}, m[WIDTH-1:0]} * {{WIDTH{1'b0}}, SP_W});

  // A period shorter than two ticks can only be a glitch, so it never agrees.
  function automatic logic agrees(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (a >= TWO_W) && (diff <= TOL_W);
  endfunction

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise) begin
          cand_d  = m[WIDTH-1:0];
          match_d = MATCH_ONE;
          state_d = CHECK;
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      CHECK: begin
        if (rise) begin
          if (agrees(m, {1'b0, cand_q})) begin
            match_d = match_q + MATCH_ONE;
            if (match_d == STABLE_M) begin
              load    = 1'b1;
              state_d = LOCKED;
            end
          end else begin
            cand_d  = m[WIDTH-1:0];
            match_d = MATCH_ONE;
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!agrees(m, {1'b0, ticks_q})) begin
            cand_d  = m[WIDTH-1:0];
            match_d = MATCH_ONE;
            state_d = CHECK;
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOST: if (rise) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      match_q <= '0;
      ticks_q <= '0;
      ref_q   <= '0;
    end else if (bus.pwrdwn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      match_q <= '0;
      ticks_q <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      if (rise)                cnt_q <= '0;
      else if (cnt_q != MAX_W) cnt_q <= cnt_q + ONE_C;
      if (load) begin
        ticks_q <= m[WIDTH-1:0];
        ref_q   <= ref_d;
      end
    end
  end

  // Held outputs stay at the last locked value until the next lock.
  assign bus.period_ticks  = ticks_q;
  assign bus.ref_period    = ref_q;
  assign bus.period_stable = (state_q == LOCKED);
  assign bus.lost          = (state_q == LOST);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a period-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and values.
`timescale 1ns/100ps
module tb_period_meter;

  localparam int WIDTH  = 32;
  localparam int TOL    = 1;
  localparam int STABLE = 4;
  localparam int MAXT   = 100;
  localparam int SP_A   = 1;
  localparam int SP_B   = 5;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_in = 1'b0;
  logic pwrdwn = 1'b0;

  period_meter_if #(.WIDTH(WIDTH)) bus_a ();
  period_meter_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_a.clk_in = clk_in;
  assign bus_b.clk_in = clk_in;
  assign bus_a.pwrdwn = pwrdwn;
  assign bus_b.pwrdwn = pwrdwn;

  period_meter #(.WIDTH(WIDTH), .SAMPLE_PERIOD(SP_A), .TOLERANCE(TOL),
                 .STABLE_CYCLES(STABLE), .MAX_TICKS(MAXT))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  period_meter #(.WIDTH(WIDTH), .SAMPLE_PERIOD(SP_B), .TOLERANCE(TOL),
                 .STABLE_CYCLES(STABLE), .MAX_TICKS(MAXT))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #0.5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $realtime);
  endtask

  // ---------------- reference model (period level) ----------------
  typedef enum {P_IDLE, P_FIRST, P_RUN, P_LOCK, P_LOST} phase_t;
  phase_t phase  = P_IDLE;
  bit     hist [3] = '{1'b0, 1'b0, 1'b0};
  int     cyc    = 0;
  int     last_e = 0;
  int     cand   = 0;
  int     run    = 0;
  int     held   = 0;

  function automatic bit near(input int a, input int b);
    int d;
    d = (a > b) ? a - b : b - a;
    return (a >= 2) && (d <= TOL);
  endfunction

  always @(posedge clk) begin : model
    bit e;
    int age;
    int m;
    if (!rst_n) begin
      phase  = P_IDLE;
      hist   = '{1'b0, 1'b0, 1'b0};
      last_e = cyc;
      cand   = 0;
      run    = 0;
      held   = 0;
    end else begin
      // A clk_in rise sampled at cycle k is seen by the meter at cycle k+2.
      e    = hist[1] && !hist[0];
      hist = '{hist[1], hist[2], clk_in};
      age  = cyc - last_e;
      m    = (age > MAXT + 1) ? MAXT + 1 : age;
      if (pwrdwn) begin
        phase  = P_IDLE;
        held   = 0;
        last_e = cyc;
      end else if (e) begin
        last_e = cyc;
        case (phase)
          P_IDLE, P_LOST: phase = P_FIRST;
          P_FIRST: begin cand = m; run = 1; phase = P_RUN; end
          P_RUN: begin
            if (near(m, cand)) begin
              run++;
              if (run == STABLE) begin held = m; phase = P_LOCK; end
            end else begin
              cand = m; run = 1;
            end
          end
          P_LOCK: if (!near(m, held)) begin cand = m; run = 1; phase = P_RUN; end
          default: phase = P_IDLE;
        endcase
      end else if (phase inside {P_FIRST, P_RUN, P_LOCK} && age == MAXT) begin
        phase = P_LOST;
      end
    end
    cyc++;
    #0.2;
    check("ticks_a",  bus_a.period_ticks,  held);
    check("ref_a",    bus_a.ref_period,    held * SP_A);
    check("ref_b",    bus_b.ref_period,    held * SP_B);
    check("stable_a", bus_a.period_stable, phase == P_LOCK);
    check("lost_a",   bus_a.lost,          phase == P_LOST);
    check("stable_b", bus_b.period_stable, phase == P_LOCK);
  end

  // ---------------- stimulus ----------------
  realtime last_rise = 0.0;
  int      drops     = 0;

  task automatic run_clk(input int high, input int low, input int n);
    for (int i = 0; i < n; i++) begin
      clk_in    = 1'b1;
      last_rise = $realtime;
      #(high);
      clk_in = 1'b0;
      #(low);
    end
  endtask

  task automatic pins(input string tag, input int ticks, input bit stable, input bit lost);
    check({tag, "/ticks_a"},  bus_a.period_ticks,  ticks);
    check({tag, "/ticks_b"},  bus_b.period_ticks,  ticks);
    check({tag, "/ref_a"},    bus_a.ref_period,    ticks * SP_A);
    check({tag, "/ref_b"},    bus_b.ref_period,    ticks * SP_B);
    check({tag, "/stable_a"}, bus_a.period_stable, stable);
    check({tag, "/lost_a"},   bus_a.lost,          lost);
  endtask

  initial begin
    #2;
    pins("reset", 0, 0, 0);
    #3.1 rst_n = 1'b1;
    #4.9;

    // 20 ns reference: fifth detected edge locks, 2.5 ns after its rise at t=90.
    fork
      run_clk(10, 10, 8);
      begin
        #82.2 check("lock20_before", bus_a.period_stable, 0);
        #0.5  check("lock20_after",  bus_a.period_stable, 1);
      end
    join
    pins("lock20", 20, 1, 0);

    run_clk(5, 5, 10);
    pins("lock10", 10, 1, 0);

    run_clk(10, 10, 8);
    pins("relock20", 20, 1, 0);

    // Alternating 19/21 ns stays within tolerance of the locked 20.
    fork
      for (int i = 0; i < 4; i++) begin
        run_clk(10, 9, 1);
        run_clk(10, 11, 1);
      end
      repeat (160) begin
        @(negedge clk);
        if (!bus_a.period_stable) drops++;
      end
    join
    check("jitter_drops", drops, 0);
    pins("jitter", 20, 1, 0);

    // Reference stops: loss is declared 100 ticks after the last edge pulse.
    #(last_rise + 102.2 - $realtime);
    check("timeout_before_lost",   bus_a.lost,          0);
    check("timeout_before_stable", bus_a.period_stable, 1);
    #0.5;
    check("timeout_lost",   bus_a.lost,          1);
    check("timeout_stable", bus_a.period_stable, 0);
    check("timeout_ticks",  bus_a.period_ticks,  20);
    #8.3;

    fork
      run_clk(10, 10, 8);
      begin
        #2.2 check("restart_lost_before", bus_a.lost, 1);
        #0.5 check("restart_lost_after",  bus_a.lost, 0);
      end
    join
    pins("after_lost", 20, 1, 0);

    // Three-cycle power-down pulse.
    @(posedge clk);
    #0.4 pwrdwn = 1'b1;
    @(posedge clk);
    #0.2 pins("pwrdwn", 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #0.4 pwrdwn = 1'b0;
    #0.1;
    run_clk(10, 10, 8);
    pins("pd_relock", 20, 1, 0);

    // Asynchronous reset mid-lock; release at T+37.1, first rise at T+40.
    fork
      run_clk(10, 10, 10);
      begin
        #31.3 rst_n = 1'b0;
        #0.1  pins("async_rst", 0, 0, 0);
        #5.7  rst_n = 1'b1;
        #85.1 check("rst_relock_before", bus_a.period_stable, 0);
        #0.5  check("rst_relock_after",  bus_a.period_stable, 1);
      end
    join
    pins("rst_relock", 20, 1, 0);

    // 22 ns differs by 2 > tolerance: lock drops, then relocks at 22.
    run_clk(10, 12, 2);
    pins("tol_break", 20, 0, 0);
    run_clk(10, 12, 6);
    pins("lock22", 22, 1, 0);

    #5;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
